// File: rtl/pixel_framebuffer.sv
// 160x120 3-bit framebuffer: plot port writes, raster scan port reads, writes take priority.
// Optional PIXEL_FB_CLEAR_EN runs a colour-0 clear sweep after every reset release.
module pixel_framebuffer (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    input  logic       scan_en,
    output logic [2:0] pix_colour,
    output logic [7:0] pix_x,
    output logic [6:0] pix_y,
    output logic       pix_valid,
    output logic       frame_start,
    output logic       busy,
    output logic [7:0] drop_count
);
    localparam int unsigned NPIX = 19200;

    logic [2:0]  r_mem [0:NPIX-1];
    logic [7:0]  r_scan_x;
    logic [6:0]  r_scan_y;
    logic [2:0]  r_pix_colour;
    logic [7:0]  r_pix_x;
    logic [6:0]  r_pix_y;
    logic        r_pix_valid;
    logic        r_frame_start;
    logic [7:0]  r_drop_count;

    logic        w_busy;
    logic        w_clr_we;
    logic [14:0] w_clr_addr;
    logic [14:0] w_plot_addr;
    logic [14:0] w_scan_addr;
    logic        w_plot_ok;
    logic        w_read;
    logic        w_we;
    logic [14:0] w_addr;
    logic [2:0]  w_wdata;
    logic [2:0]  w_rdata;

`ifdef PIXEL_FB_CLEAR_EN
    logic        r_busy;
    logic [14:0] r_clr_addr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy     <= 1'b1;
            r_clr_addr <= '0;
        end else if (r_busy) begin
            if (r_clr_addr == 15'(NPIX - 1))
                r_busy <= 1'b0;
            else
                r_clr_addr <= r_clr_addr + 15'd1;
        end
    end

    assign w_busy     = r_busy;
    assign w_clr_we   = r_busy;
    assign w_clr_addr = r_clr_addr;
`else
    assign w_busy     = 1'b0;
    assign w_clr_we   = 1'b0;
    assign w_clr_addr = '0;
`endif

    // y*160 + x without a multiplier
    assign w_plot_addr = ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
    assign w_scan_addr = ({8'd0, r_scan_y} << 7) + ({8'd0, r_scan_y} << 5) + {7'd0, r_scan_x};

    assign w_plot_ok = plot && (x < 8'd160) && (y < 7'd120) && !w_busy;
    assign w_read    = scan_en && !w_plot_ok && !w_busy;
    assign w_we      = w_clr_we || w_plot_ok;
    assign w_wdata   = w_clr_we ? 3'd0 : colour;
    assign w_addr    = w_clr_we ? w_clr_addr : (w_plot_ok ? w_plot_addr : w_scan_addr);
    assign w_rdata   = r_mem[w_addr];

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_addr] <= w_wdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_scan_x      <= '0;
            r_scan_y      <= '0;
            r_pix_colour  <= '0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_pix_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_drop_count  <= '0;
        end else begin
            r_pix_valid   <= w_read;
            r_frame_start <= w_read && (r_scan_x == 8'd0) && (r_scan_y == 7'd0);
            if (w_read) begin
                r_pix_colour <= w_rdata;
                r_pix_x      <= r_scan_x;
                r_pix_y      <= r_scan_y;
                if (r_scan_x == 8'd159) begin
                    r_scan_x <= '0;
                    r_scan_y <= (r_scan_y == 7'd119) ? 7'd0 : r_scan_y + 7'd1;
                end else begin
                    r_scan_x <= r_scan_x + 8'd1;
                end
            end
            if (plot && !w_plot_ok && (r_drop_count != 8'hFF))
                r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign pix_colour  = r_pix_colour;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pix_valid   = r_pix_valid;
    assign frame_start = r_frame_start;
    assign busy        = w_busy;
    assign drop_count  = r_drop_count;
endmodule

// File: tb/tb_pixel_framebuffer.sv
// Scoreboard bench for pixel_framebuffer: stimulus pushes expected pixels, a negedge monitor pops and compares.
module tb_pixel_framebuffer;
    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic [2:0] colour = '0;
    logic       plot = 1'b0;
    logic       scan_en = 1'b0;
    logic [2:0] pix_colour;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic       pix_valid;
    logic       frame_start;
    logic       busy;
    logic [7:0] drop_count;

`ifdef PIXEL_FB_CLEAR_EN
    localparam int CLEAR_CYCLES = 19200;
    localparam int CLR_DROPS    = 3;
`else
    localparam int CLEAR_CYCLES = 0;
    localparam int CLR_DROPS    = 0;
`endif

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] c;
        logic       known;
        logic       fs;
    } exp_t;

    exp_t       expQ[$];
    int         checks = 0;
    int         failures = 0;
    int         sx = 0;
    int         sy = 0;
    int         busyLeft = 0;
    logic [2:0] memM [0:19199];
    bit         knownM [0:19199];
    int         fsCount = 0;
    logic [7:0] lastX = '0;
    logic [6:0] lastY = '0;
    logic [7:0] wrapPrevX = '0;
    logic [6:0] wrapPrevY = '0;

    pixel_framebuffer dut (
        .clk(clk), .resetn(resetn), .x(x), .y(y), .colour(colour), .plot(plot),
        .scan_en(scan_en), .pix_colour(pix_colour), .pix_x(pix_x), .pix_y(pix_y),
        .pix_valid(pix_valid), .frame_start(frame_start), .busy(busy), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock of stimulus; the model decides whether a read issues and queues its expected pixel.
    task automatic applyStimulus(input logic p, input int px, input int py, input int pc, input logic se);
        bit   acc;
        bit   rd;
        int   a;
        exp_t e;
        plot    = p;
        x       = 8'(px);
        y       = 7'(py);
        colour  = 3'(pc);
        scan_en = se;
        checkOutput("busy", int'(busy), int'(busyLeft > 0));
        acc = p && (px < 160) && (py < 120) && (busyLeft == 0);
        rd  = se && !acc && (busyLeft == 0);
        e   = '0;
        if (rd) begin
            a       = sy * 160 + sx;
            e.px    = 8'(sx);
            e.py    = 7'(sy);
            e.c     = memM[a];
            e.known = knownM[a];
            e.fs    = (sx == 0) && (sy == 0);
        end
        @(posedge clk);
        if (rd) begin
            expQ.push_back(e);
            if (sx == 159) begin
                sx = 0;
                sy = (sy == 119) ? 0 : sy + 1;
            end else begin
                sx = sx + 1;
            end
        end
        if (acc) begin
            memM[py * 160 + px]   = 3'(pc);
            knownM[py * 160 + px] = 1'b1;
        end
        if (busyLeft > 0) busyLeft--;
        #1;
    endtask

    task automatic releaseReset();
        @(negedge clk);
        resetn = 1'b1;
        sx = 0;
        sy = 0;
        busyLeft = CLEAR_CYCLES;
        if (CLEAR_CYCLES > 0)
            for (int i = 0; i < 19200; i++) begin
                memM[i]   = 3'd0;
                knownM[i] = 1'b1;
            end
    endtask

    task automatic waitClear();
        if (CLEAR_CYCLES > 0) begin
            for (int i = 0; i < CLR_DROPS; i++) applyStimulus(1'b1, 10, 10, 7, 1'b1);
            while (busyLeft > 0) applyStimulus(1'b0, 0, 0, 0, 1'b1);
            applyStimulus(1'b0, 0, 0, 0, 1'b0);
            checkOutput("drops_during_clear", int'(drop_count), CLR_DROPS);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            checks++;
            if (pix_valid !== (expQ.size() != 0)) begin
                failures++;
                $display("[TB] FAIL pix_valid: got %b, expected %b", pix_valid, expQ.size() != 0);
            end
            if (pix_valid !== 1'b1 && frame_start !== 1'b0) begin
                failures++;
                $display("[TB] FAIL idle_frame_start: got %b, expected 0", frame_start);
            end
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                if (pix_valid === 1'b1) begin
                    checks++;
                    if (pix_x !== e.px || pix_y !== e.py || frame_start !== e.fs ||
                        (e.known && pix_colour !== e.c)) begin
                        failures++;
                        $display("[TB] FAIL pixel: got (%0d,%0d) c=%0d fs=%b, expected (%0d,%0d) c=%0d fs=%b",
                                 pix_x, pix_y, pix_colour, frame_start, e.px, e.py, e.c, e.fs);
                    end
                    if (frame_start === 1'b1) begin
                        if (fsCount > 0) begin
                            wrapPrevX = lastX;
                            wrapPrevY = lastY;
                        end
                        fsCount++;
                    end
                    lastX = pix_x;
                    lastY = pix_y;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 19200; i++) begin
            memM[i]   = 3'd0;
            knownM[i] = 1'b0;
        end
        #1 resetn = 1'b0;
        #20;
        checkOutput("rst_pix_valid", int'(pix_valid), 0);
        checkOutput("rst_frame_start", int'(frame_start), 0);
        checkOutput("rst_pix_colour", int'(pix_colour), 0);
        checkOutput("rst_pix_x", int'(pix_x), 0);
        checkOutput("rst_pix_y", int'(pix_y), 0);
        checkOutput("rst_drop_count", int'(drop_count), 0);
        releaseReset();
        waitClear();

        applyStimulus(1'b1, 0, 0, 2, 1'b0);
        applyStimulus(1'b1, 0, 1, 5, 1'b0);
        applyStimulus(1'b1, 159, 119, 6, 1'b0);
        applyStimulus(1'b1, 5, 2, 3, 1'b0);
        applyStimulus(1'b1, 160, 0, 7, 1'b0);
        applyStimulus(1'b1, 0, 120, 7, 1'b0);
        checkOutput("drop_two_bad", int'(drop_count), CLR_DROPS + 2);

        // Alternate plot/idle while scanning: 20 reads, plots land ahead of the scan in row 5.
        for (int k = 0; k < 40; k++)
            applyStimulus(k[0], 100 + k, 5, k % 8, 1'b1);
        for (int k = 0; k < 19181; k++)
            applyStimulus(1'b0, 0, 0, 0, 1'b1);
        applyStimulus(1'b0, 0, 0, 0, 1'b0);
        checkOutput("frame_start_count", fsCount, 2);
        checkOutput("wrap_prev_x", int'(wrapPrevX), 159);
        checkOutput("wrap_prev_y", int'(wrapPrevY), 119);

        for (int k = 0; k < 300; k++)
            applyStimulus(1'b1, 200, 0, 1, 1'b0);
        checkOutput("drop_saturate", int'(drop_count), 255);

        resetn = 1'b0;
        #3;
        releaseReset();
        waitClear();
        checkOutput("drop_after_reset", int'(drop_count), CLR_DROPS);
        for (int k = 0; k < 9680; k++)
            applyStimulus(1'b0, 0, 0, 0, 1'b1);
        checkOutput("mid_pix_x", int'(pix_x), 79);
        checkOutput("mid_pix_y", int'(pix_y), 60);
        #1;
        resetn = 1'b0;
        expQ.delete();
        #1;
        checkOutput("async_pix_valid", int'(pix_valid), 0);
        checkOutput("async_pix_x", int'(pix_x), 0);
        checkOutput("async_pix_y", int'(pix_y), 0);
        releaseReset();
        waitClear();
        applyStimulus(1'b0, 0, 0, 0, 1'b1);
        checkOutput("restart_valid", int'(pix_valid), 1);
        checkOutput("restart_x", int'(pix_x), 0);
        checkOutput("restart_y", int'(pix_y), 0);
        checkOutput("restart_frame_start", int'(frame_start), 1);
        applyStimulus(1'b0, 0, 0, 0, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 1'b0);
        checkOutput("queue_drained", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pixel_framebuffer.md
PIXEL_FRAMEBUFFER -- requirements
Module: pixel_framebuffer

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low; ports clk and resetn.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all logic.
REQ-003 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port x  input  8  plot column, valid 0..159.
REQ-005 SHALL have port y  input  7  plot row, valid 0..119.
REQ-006 SHALL have port colour  input  3  plot colour.
REQ-007 SHALL have port plot  input  1  write strobe, one pixel per cycle high.
REQ-008 SHALL have port scan_en  input  1  request to advance raster readout.
REQ-009 SHALL have port pix_colour  output  3  colour read from memory.
REQ-010 SHALL have port pix_x  output  8  column of pix_colour.
REQ-011 SHALL have port pix_y  output  7  row of pix_colour.
REQ-012 SHALL have port pix_valid  output  1  pix_* outputs valid this cycle.
REQ-013 SHALL have port frame_start  output  1  pulse with pix_valid for pixel (0,0).
REQ-014 SHALL have port busy  output  1  clear sweep in progress.
REQ-015 SHALL have port drop_count  output  8  saturating count of rejected plots.

Function
REQ-016 SHALL store 19200 3-bit pixels in a single-port memory; address = y*160 + x, 15 bits, computed as (y<<7)+(y<<5)+x.
REQ-017 SHALL accept a plot on a rising edge when plot=1, x<160, y<120 and busy=0; the write lands at that edge.
REQ-018 SHALL reject a plot when x>=160, y>=120 or busy=1; no memory change; drop_count +1, saturating at 255.
REQ-019 SHALL give writes priority: in a cycle with an accepted plot no read is issued and the scan counters hold.
REQ-020 SHALL issue a read when scan_en=1, no plot accepted and busy=0; scan counters advance at that edge.
REQ-021 SHALL present pix_colour, pix_x, pix_y with pix_valid=1 exactly one cycle after the read issues; pix_valid=0 otherwise, and pix_* hold their last values.
REQ-022 SHALL scan x 0..159, wrapping 159->0 with y+1; y wraps 119->0 after (159,119).
REQ-023 SHALL assert frame_start for exactly the pix_valid cycle of pixel (0,0).
REQ-024 SHALL return the newly written colour when a read follows a write to the same address by one or more cycles.
REQ-025 SHALL hold the scan position indefinitely while scan_en=0 or writes stall it; no pixel is skipped or repeated.

Reset
REQ-026 SHALL on resetn=0 immediately force pix_valid=0, frame_start=0, pix_colour=0, pix_x=0, pix_y=0, drop_count=0, scan counters to (0,0), and abort any sweep or pending read.
REQ-027 SHALL set busy after reset deassertion per REQ-028/029; memory contents are not reset by resetn.

Configuration
REQ-028 SHALL, with PIXEL_FB_CLEAR_EN defined, run a clear sweep after reset release: busy=1 and colour 0 written to addresses 0..19199, one per cycle; busy falls the cycle after address 19199 is written (19200 cycles of busy); reads and plots are blocked and plots are counted as drops.
REQ-029 SHALL, without PIXEL_FB_CLEAR_EN, hold busy=0 permanently; memory content after power-up is undefined.

Verification
REQ-030 SHALL cover: plot (x=5,y=2,colour=3), then scan to address 325 -> pix_valid with pix_x=5, pix_y=2, pix_colour=3.
REQ-031 SHALL cover: plot x=160,y=0 then x=0,y=120 -> memory unchanged, drop_count=2; 300 bad plots -> drop_count=255.
REQ-032 SHALL cover: scan_en=1 with plot high on alternate cycles -> reads only in non-plot cycles, pixel sequence contiguous, no gaps or repeats.
REQ-033 SHALL cover: continuous scan_en for 19201 reads -> frame_start on read 1 and read 19201 only, pix (159,119) precedes the wrap.
REQ-034 SHALL cover: with PIXEL_FB_CLEAR_EN, release reset -> busy high exactly 19200 cycles, every scanned pixel reads 0, plots during busy counted as drops.
REQ-035 SHALL cover: assert resetn=0 mid-scan at (80,60) -> pix_valid=0 asynchronously, scan restarts at (0,0) after release.
